scrambler_par: RTL
==================

Name: scrambler_par

Overview:
- Parametrised, parallel-word successor to the team's 12-bit serial additive scrambler.
- Processes DATA_W bits per accepted beat, LSB first, using a configurable Fibonacci LFSR.
- Runtime mode select: additive, self-synchronising multiplicative scramble or descramble, or bypass.
- Adds a valid/ready stream handshake, runtime seed load, and state observability; sits between the framer and the line serializer.

Parameters:
- LFSR_W, 12, LFSR length in bits (>=2).
- TAPS, 12'h409, LFSR_W-bit tap mask; feedback = XOR of q[i] where TAPS[i]=1 (default: q[10]^q[3]^q[0]).
- SEED, 12'h14D, LFSR_W-bit reset and power-up state.
- DATA_W, 8, bits processed per beat (1..64).

Ports:
- CLK_I  in  1  clock; all logic on rising edge.
- RST_N_I  in  1  asynchronous active-low reset.
- MODE_I  in  2  00 additive, 01 multiplicative scramble, 10 multiplicative descramble, 11 bypass; sampled on accepted beat.
- LOAD_I  in  1  load SEED_I into LFSR this cycle.
- SEED_I  in  LFSR_W  runtime seed.
- IN_VALID_I  in  1  input beat valid.
- IN_READY_O  out  1  block can accept a beat.
- DATA_I  in  DATA_W  input word.
- OUT_VALID_O  out  1  output word valid.
- OUT_READY_I  in  1  downstream accepts.
- DATA_O  out  DATA_W  processed word.
- STATE_O  out  LFSR_W  current LFSR state.
- ZERO_LOCK_O  out  1  LFSR all-zero (additive keystream stuck at 0).

Behaviour:
- Reset (async assert, sync release): q=SEED; OUT_VALID_O=0; DATA_O=0; STATE_O=SEED; ZERO_LOCK_O=(SEED==0).
- IN_READY_O = !OUT_VALID_O || OUT_READY_I (combinational). Accept = IN_VALID_I && IN_READY_O.
- Output register is a 1-stage pipeline: an accepted beat appears on DATA_O next cycle with OUT_VALID_O=1.
- OUT_VALID_O clears when OUT_READY_I=1 and no new beat is accepted.
- While OUT_VALID_O=1 and OUT_READY_I=0: DATA_O, OUT_VALID_O, and q are held; the input is stalled.
- Start state: s = LOAD_I ? SEED_I : q.
- Per-bit unrolled recurrence, i = 0..DATA_W-1:
  - fb = ^(s & TAPS); o[i] = DATA_I[i] ^ fb.
  - Next s = {x, s[LFSR_W-1:1]}, where x = fb (additive), o[i] (mult scramble), or DATA_I[i] (mult descramble).
  - Bypass: o = DATA_I; s unchanged.
- On accept: DATA_O <= o; q <= final s.
- LOAD_I without accept: q <= SEED_I. LOAD_I with accept: the beat uses SEED_I as its start state, and q <= the post-beat state.
- q changes only on accept or LOAD_I. A stall with LOAD_I=1 still loads.
- DATA_W=1 with MODE_I=00 is bit-exact with the legacy serial scrambler.
- Mode changes take effect on the next accepted beat; the LFSR state is retained across mode changes.
- STATE_O = q (registered). ZERO_LOCK_O = (q==0), registered alongside q.
- Mult modes self-recover from zero state via data; ZERO_LOCK_O is informational only.
- Reset mid-stream: the in-flight output word is dropped; OUT_VALID_O=0 immediately (async).
- Full throughput: one beat per cycle when OUT_READY_I stays 1.

Test Plan:
- Reset, MODE_I=00, DATA_I=0x00 one beat -> next cycle DATA_O=0xB4, OUT_VALID_O=1, STATE_O=0xB41.
- DATA_W=1, MODE_I=00, 1000 random bits -> output matches the legacy serial scrambler model bit-for-bit.
- Instance A in mode 01 feeding instance B in mode 10 with a different seed, 200 random bytes:
  - B output equals A input from byte 2 onward (12-bit sync window).
  - Mismatch is confined to the first 12 bits.
- Backpressure: hold OUT_READY_I=0 for 5 cycles with IN_VALID_I=1 -> IN_READY_O=0, DATA_O and STATE_O stable; on release, beats resume in order with none lost or duplicated.
- LOAD_I=1, SEED_I=0x14D coincident with an accepted 0x00 beat, from any prior state -> DATA_O=0xB4, STATE_O=0xB41.
- LOAD_I with SEED_I=0 in mode 00 -> ZERO_LOCK_O=1, DATA_O=DATA_I. Mode 11 -> DATA_O=DATA_I and STATE_O unchanged. Assert RST_N_I mid-stream -> OUT_VALID_O=0 at once, STATE_O=0x14D.

Source files
------------

// File: rtl/scrambler_par.sv
// ---------------------------------------------------------------------------
// scrambler_par
//
// Parallel-word LFSR scrambler/descrambler with a valid/ready stream
// interface. It processes DATA_W bits per accepted beat, LSB first, through
// a Fibonacci LFSR of length LFSR_W. The feedback bit is the XOR of every
// state bit q[i] for which TAPS[i]=1.
//
// The mode is selected at run time and sampled on each accepted beat:
//   00 additive, 01 multiplicative scramble,
//   10 multiplicative descramble, 11 bypass.
//
// Ports:
//   CLK_I        clock, rising edge
//   RST_N_I      asynchronous active-low reset
//   MODE_I       processing mode, sampled on an accepted beat
//   LOAD_I       load SEED_I into the LFSR this cycle
//   SEED_I       runtime seed
//   IN_VALID_I   input beat valid
//   IN_READY_O   block can accept a beat (combinational)
//   DATA_I       input word
//   OUT_VALID_O  output word valid
//   OUT_READY_I  downstream accepts the output word
//   DATA_O       processed word (registered)
//   STATE_O      current LFSR state (registered)
//   ZERO_LOCK_O  LFSR state is all-zero (registered alongside the state)
// ---------------------------------------------------------------------------
module scrambler_par #(
  parameter int                LFSR_W = 12,
  parameter logic [LFSR_W-1:0] TAPS   = 12'h409,
  parameter logic [LFSR_W-1:0] SEED   = 12'h14D,
  parameter int                DATA_W = 8
) (
  input  logic              CLK_I,
  input  logic              RST_N_I,
  input  logic [1:0]        MODE_I,
  input  logic              LOAD_I,
  input  logic [LFSR_W-1:0] SEED_I,
  input  logic              IN_VALID_I,
  output logic              IN_READY_O,
  input  logic [DATA_W-1:0] DATA_I,
  output logic              OUT_VALID_O,
  input  logic              OUT_READY_I,
  output logic [DATA_W-1:0] DATA_O,
  output logic [LFSR_W-1:0] STATE_O,
  output logic              ZERO_LOCK_O
);

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_MSCR = 2'b01;
  localparam logic [1:0] MODE_BYP  = 2'b11;

  logic [LFSR_W-1:0] state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              out_valid_q, out_valid_d;
  logic              zero_lock_q, zero_lock_d;

  logic              accept;
  logic [LFSR_W-1:0] s_cur;
  logic [DATA_W-1:0] o_w;
  logic              fb_bit;
  logic              x_bit;

  // A held output word blocks the input only while downstream is stalled.
  assign IN_READY_O = !out_valid_q || OUT_READY_I;
  assign accept     = IN_VALID_I && IN_READY_O;

  // Unrolled per-bit recurrence. A load coincident with a beat seeds that
  // beat, so the start state is chosen before the bit loop runs.
  always_comb begin
    s_cur  = LOAD_I ? SEED_I : state_q;
    o_w    = DATA_I;
    fb_bit = 1'b0;
    x_bit  = 1'b0;
    if (MODE_I != MODE_BYP) begin
      for (int i = 0; i < DATA_W; i++) begin
        fb_bit = ^(s_cur & TAPS);
        o_w[i] = DATA_I[i] ^ fb_bit;
        // Additive runs free; the multiplicative modes shift in the
        // scrambled bit, which is what lets a descrambler self-synchronise.
        case (MODE_I)
          MODE_ADD:  x_bit = fb_bit;
          MODE_MSCR: x_bit = o_w[i];
          default:   x_bit = DATA_I[i];
        endcase
        s_cur = {x_bit, s_cur[LFSR_W-1:1]};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      state_d     = s_cur;
      data_d      = o_w;
      out_valid_d = 1'b1;
    end else begin
      // A load still lands during a stall; only the beat is held off.
      if (LOAD_I) begin
        state_d = SEED_I;
      end
      if (OUT_READY_I) begin
        out_valid_d = 1'b0;
      end
    end
    zero_lock_d = (state_d == '0);
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q     <= SEED;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      zero_lock_q <= (SEED == '0);
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      zero_lock_q <= zero_lock_d;
    end
  end

  assign OUT_VALID_O = out_valid_q;
  assign DATA_O      = data_q;
  assign STATE_O     = state_q;
  assign ZERO_LOCK_O = zero_lock_q;

endmodule
